fir_xifu_scoreboard: RTL and testbench
======================================

Name: fir_xifu_scoreboard

Overview:
- Issue/commit scheduler for the FIR XIFU pipeline.
- Tracks every in-flight offloaded instruction by XIF id and keeps a busy bit per XIFU register.
- Gates issue acceptance on RAW/WAW hazards and slot availability.
- Frees entries on writeback or commit-kill, and produces the pipeline kill pulse that drives the ID/EX clear.

Parameters:
NB_REGS, 4, number of XIFU-internal registers tracked (≥2)
ID_WIDTH, 4, width of XIF instruction id
MAX_INFLIGHT, 4, number of tracking slots (max outstanding instructions)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  ID stage presents decoded XIFU instruction
issue_ready_o  out  1  scoreboard accepts instruction this cycle
issue_id_i  in  ID_WIDTH  XIF id of issuing instruction
issue_rs_mask_i  in  NB_REGS  one-hot-or-zero set of XIFU registers read
issue_rd_valid_i  in  1  instruction writes an XIFU register
issue_rd_i  in  $clog2(NB_REGS)  destination register index
commit_valid_i  in  1  XIF commit handshake
commit_id_i  in  ID_WIDTH  id being committed/killed
commit_kill_i  in  1  commit is a kill
wb_valid_i  in  1  WB stage finished instruction (regfile written)
wb_id_i  in  ID_WIDTH  id finishing
busy_o  out  NB_REGS  registers with pending write
inflight_o  out  $clog2(MAX_INFLIGHT+1)  occupied slot count
full_o  out  1  all slots occupied
kill_o  out  1  one-cycle pipeline clear pulse

Behaviour:
- Slot state, per slot: valid, id, committed, done, rd_valid, rd.
- Outputs are derived from registered slot state only. A slot freed in cycle N becomes usable, and its busy bit clears, in cycle N+1.
- busy_o = OR over valid slots with rd_valid of onehot(rd).
- inflight_o = popcount(valid).
- full_o = (inflight_o == MAX_INFLIGHT).
- issue_ready_o is combinational and independent of issue_valid_i. It is high iff all of:
  - !full_o
  - (issue_rs_mask_i & busy_o) == 0 (no RAW)
  - !(issue_rd_valid_i && busy_o[issue_rd_i]) (no WAW)
  - no valid slot holds issue_id_i (duplicate id stalls)
- Accept = issue_valid_i && issue_ready_o. On accept, allocate the lowest-index free slot: valid=1, committed=0, done=0, id/rd captured.
- Commit, on commit_valid_i with a matching valid slot:
  - kill=0: set committed. If done is already set, free the slot.
  - kill=1: free the slot and assert kill_o for exactly one cycle (registered, cycle N+1).
  - No matching slot: ignored, no kill_o.
- Writeback, on wb_valid_i with a matching slot:
  - Slot committed: free it.
  - Slot uncommitted: set done. The slot frees at the later non-kill commit, or on a kill.
  - Unknown id: ignored.
- Simultaneous events:
  - Commit (non-kill) and wb to the same id in one cycle: slot freed.
  - Kill and wb to the same id: slot freed, kill_o still pulses.
  - Accept plus free of different slots in one cycle: both take effect; inflight_o reflects the net result.
  - Accept id equal to a slot being freed that cycle: stalled (duplicate check uses current state).
- Kill scope: frees only the matching slot. Younger entries are freed by their own kill commits.
- Reset: all slots invalid; busy_o=0, inflight_o=0, full_o=0, kill_o=0. Reset mid-operation drops all entries, with no kill_o pulse generated.
- Latency: issue decision 0 cycles (combinational). State update, busy/full visibility and kill_o take effect 1 cycle later.

Test Plan:
- Reset then issue id=1, rd=2, rs=0 -> ready=1; next cycle busy_o=4'b0100, inflight_o=1.
- With id=1 pending on r2, issue id=2 rs_mask=4'b0100 -> ready=0. wb id=1 after commit -> next cycle busy_o=0, ready=1.
- Issue ids 0..3 writing r0..r3 -> full_o=1. A fifth issue with rd_valid=0, rs=0 -> ready=0 until one slot frees.
- Issue id=5 rd=1, commit_kill id=5 -> kill_o high exactly one cycle later; busy_o[1]=0, inflight_o=0.
- Issue id=3 rd=0; wb id=3 before commit -> busy_o[0] stays 1. Commit id=3 non-kill -> busy_o[0]=0 the following cycle.
- Commit and wb for id=7 in the same cycle -> slot freed; issue id=7 with rd=3 in that same cycle -> ready=0, and ready=1 the next cycle.

Source files
------------

// File: rtl/fir_xifu_scoreboard.sv
// Issue/commit scoreboard for the FIR XIFU pipeline: tracks in-flight offloaded
// instructions by XIF id, keeps per-register busy bits and gates issue on hazards.
module fir_xifu_scoreboard #(
  parameter int NB_REGS      = 4,
  parameter int ID_WIDTH     = 4,
  parameter int MAX_INFLIGHT = 4,
  localparam int RD_W        = $clog2(NB_REGS),
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [NB_REGS-1:0]  issue_rs_mask_i,
  input  logic                issue_rd_valid_i,
  input  logic [RD_W-1:0]     issue_rd_i,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  input  logic                wb_valid_i,
  input  logic [ID_WIDTH-1:0] wb_id_i,
  output logic [NB_REGS-1:0]  busy_o,
  output logic [CNT_W-1:0]    inflight_o,
  output logic                full_o,
  output logic                kill_o
);

  logic [MAX_INFLIGHT-1:0] valid_q, valid_d;
  logic [MAX_INFLIGHT-1:0] committed_q, committed_d;
  logic [MAX_INFLIGHT-1:0] done_q, done_d;
  logic [MAX_INFLIGHT-1:0] rd_valid_q, rd_valid_d;
  logic [ID_WIDTH-1:0]     id_q [MAX_INFLIGHT];
  logic [ID_WIDTH-1:0]     id_d [MAX_INFLIGHT];
  logic [RD_W-1:0]         rd_q [MAX_INFLIGHT];
  logic [RD_W-1:0]         rd_d [MAX_INFLIGHT];
  logic                    kill_q, kill_d;

  logic [MAX_INFLIGHT-1:0] commit_hit, wb_hit, dup_hit, free, alloc_oh;
  logic [NB_REGS-1:0]      busy;
  logic [CNT_W-1:0]        inflight;
  logic                    full, ready, accept, alloc_found;

  // Everything visible outside is derived from registered slot state only.
  always_comb begin
    busy     = '0;
    inflight = '0;
    for (int s = 0; s < MAX_INFLIGHT; s++) begin
      if (valid_q[s] && rd_valid_q[s]) busy[rd_q[s]] = 1'b1;
      inflight = inflight + CNT_W'(valid_q[s]);
    end
  end

  always_comb begin
    for (int s = 0; s < MAX_INFLIGHT; s++) begin
      commit_hit[s] = commit_valid_i && valid_q[s] && (id_q[s] == commit_id_i);
      wb_hit[s]     = wb_valid_i && valid_q[s] && (id_q[s] == wb_id_i);
      dup_hit[s]    = valid_q[s] && (id_q[s] == issue_id_i);
      free[s]       = (commit_hit[s] && (commit_kill_i || done_q[s] || wb_hit[s])) ||
                      (wb_hit[s] && committed_q[s]);
    end
  end

  assign full  = (inflight == CNT_W'(MAX_INFLIGHT));
  assign ready = !full &&
                 ((issue_rs_mask_i & busy) == '0) &&
                 !(issue_rd_valid_i && busy[issue_rd_i]) &&
                 (dup_hit == '0);
  assign accept = issue_valid_i && ready;

  // Lowest-index free slot; a slot freed this cycle is not reused until next cycle.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int s = 0; s < MAX_INFLIGHT; s++) begin
      if (!valid_q[s] && !alloc_found) begin
        alloc_oh[s] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_q;
    done_d      = done_q;
    rd_valid_d  = rd_valid_q;
    id_d        = id_q;
    rd_d        = rd_q;
    kill_d      = commit_valid_i && commit_kill_i && (commit_hit != '0);
    for (int s = 0; s < MAX_INFLIGHT; s++) begin
      if (free[s]) begin
        valid_d[s]     = 1'b0;
        committed_d[s] = 1'b0;
        done_d[s]      = 1'b0;
        rd_valid_d[s]  = 1'b0;
      end else if (accept && alloc_oh[s]) begin
        valid_d[s]     = 1'b1;
        committed_d[s] = 1'b0;
        done_d[s]      = 1'b0;
        rd_valid_d[s]  = issue_rd_valid_i;
        id_d[s]        = issue_id_i;
        rd_d[s]        = issue_rd_i;
      end else begin
        if (commit_hit[s] && !commit_kill_i) committed_d[s] = 1'b1;
        if (wb_hit[s]) done_d[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      committed_q <= '0;
      done_q      <= '0;
      rd_valid_q  <= '0;
      kill_q      <= 1'b0;
      for (int s = 0; s < MAX_INFLIGHT; s++) begin
        id_q[s] <= '0;
        rd_q[s] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      kill_q      <= kill_d;
      id_q        <= id_d;
      rd_q        <= rd_d;
    end
  end

  assign issue_ready_o = ready;
  assign busy_o        = busy;
  assign inflight_o    = inflight;
  assign full_o        = full;
  assign kill_o        = kill_q;

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// Directed bench for fir_xifu_scoreboard: the driver queues hand-computed output
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_fir_xifu_scoreboard;

  localparam int W = 10;  // {ready, busy[3:0], inflight[2:0], full, kill}

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_ready, issue_rd_valid;
  logic [3:0] issue_id, issue_rs_mask;
  logic [1:0] issue_rd;
  logic       commit_valid, commit_kill, wb_valid;
  logic [3:0] commit_id, wb_id;
  logic [3:0] busy;
  logic [2:0] inflight;
  logic       full, kill;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_stb = 1'b0;
  int           checks  = 0;
  int           errors  = 0;

  fir_xifu_scoreboard dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .issue_valid_i   (issue_valid),
    .issue_ready_o   (issue_ready),
    .issue_id_i      (issue_id),
    .issue_rs_mask_i (issue_rs_mask),
    .issue_rd_valid_i(issue_rd_valid),
    .issue_rd_i      (issue_rd),
    .commit_valid_i  (commit_valid),
    .commit_id_i     (commit_id),
    .commit_kill_i   (commit_kill),
    .wb_valid_i      (wb_valid),
    .wb_id_i         (wb_id),
    .busy_o          (busy),
    .inflight_o      (inflight),
    .full_o          (full),
    .kill_o          (kill)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    issue_valid = 1'b0; issue_id = '0; issue_rs_mask = '0; issue_rd_valid = 1'b0; issue_rd = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    wb_valid = 1'b0; wb_id = '0;
  endtask

  task automatic iss(input logic [3:0] id, input logic [3:0] rs, input logic rdv, input logic [1:0] rd);
    issue_valid = 1'b1; issue_id = id; issue_rs_mask = rs; issue_rd_valid = rdv; issue_rd = rd;
  endtask

  task automatic cmt(input logic [3:0] id, input logic k);
    commit_valid = 1'b1; commit_id = id; commit_kill = k;
  endtask

  task automatic wbk(input logic [3:0] id);
    wb_valid = 1'b1; wb_id = id;
  endtask

  task automatic chk(input logic r, input logic [3:0] b, input logic [2:0] inf,
                     input logic f, input logic k, input string nm);
    exp_q.push_back({r, b, inf, f, k});
    name_q.push_back(nm);
    chk_stb = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_stb = 1'b0;
    idle();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (chk_stb) begin
      logic [W-1:0] obs, exp;
      string        nm;
      obs = {issue_ready, busy, inflight, full, kill};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expectation: observed %b with empty queue", obs);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s: got rdy=%b busy=%b infl=%0d full=%b kill=%b, want rdy=%b busy=%b infl=%0d full=%b kill=%b",
                   nm, obs[9], obs[8:5], obs[4:2], obs[1], obs[0],
                   exp[9], exp[8:5], exp[4:2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    chk(1, 4'b0000, 0, 0, 0, "reset"); tick();

    // Basic issue and RAW/WAW stalls
    iss(1, 4'b0000, 1, 2); chk(1, 4'b0000, 0, 0, 0, "t1_ready"); tick();
    chk(1, 4'b0100, 1, 0, 0, "t1_busy"); tick();
    iss(2, 4'b0000, 1, 2); chk(0, 4'b0100, 1, 0, 0, "waw_stall"); tick();
    iss(2, 4'b0100, 0, 0); chk(0, 4'b0100, 1, 0, 0, "raw_stall"); tick();
    iss(2, 4'b0100, 0, 0); cmt(1, 0); chk(0, 4'b0100, 1, 0, 0, "raw_commit"); tick();
    iss(2, 4'b0100, 0, 0); wbk(1); chk(0, 4'b0100, 1, 0, 0, "raw_wb"); tick();
    iss(2, 4'b0100, 0, 0); issue_valid = 1'b0; chk(1, 4'b0000, 0, 0, 0, "raw_clear"); tick();

    // Fill every slot, stall on full, free one, refill
    iss(0, 4'b0000, 1, 0); chk(1, 4'b0000, 0, 0, 0, "fill0"); tick();
    iss(1, 4'b0000, 1, 1); chk(1, 4'b0001, 1, 0, 0, "fill1"); tick();
    iss(2, 4'b0000, 1, 2); chk(1, 4'b0011, 2, 0, 0, "fill2"); tick();
    iss(3, 4'b0000, 1, 3); chk(1, 4'b0111, 3, 0, 0, "fill3"); tick();
    iss(4, 4'b0000, 0, 0); chk(0, 4'b1111, 4, 1, 0, "full_stall"); tick();
    iss(4, 4'b0000, 0, 0); cmt(0, 0); wbk(0); chk(0, 4'b1111, 4, 1, 0, "full_free"); tick();
    iss(4, 4'b0000, 0, 0); chk(1, 4'b1110, 3, 0, 0, "full_ready"); tick();
    chk(0, 4'b1110, 4, 1, 0, "refull"); tick();
    for (int i = 1; i <= 4; i++) begin
      cmt(4'(i), 0); wbk(4'(i)); tick();
    end
    chk(1, 4'b0000, 0, 0, 0, "drained"); tick();

    // Kill pulse and unknown-id kill
    iss(5, 4'b0000, 1, 1); chk(1, 4'b0000, 0, 0, 0, "k_issue"); tick();
    cmt(5, 1); chk(1, 4'b0010, 1, 0, 0, "k_commit"); tick();
    cmt(9, 1); chk(1, 4'b0000, 0, 0, 1, "k_pulse"); tick();
    chk(1, 4'b0000, 0, 0, 0, "k_once"); tick();

    // Writeback before commit holds the busy bit
    iss(3, 4'b0000, 1, 0); chk(1, 4'b0000, 0, 0, 0, "wbc_issue"); tick();
    wbk(3); chk(1, 4'b0001, 1, 0, 0, "wbc_wb"); tick();
    chk(1, 4'b0001, 1, 0, 0, "wbc_hold"); tick();
    cmt(3, 0); chk(1, 4'b0001, 1, 0, 0, "wbc_commit"); tick();
    chk(1, 4'b0000, 0, 0, 0, "wbc_free"); tick();

    // Same-cycle commit+wb, duplicate-id stall, accept alongside free, kill+wb
    iss(7, 4'b0000, 1, 3); tick();
    iss(7, 4'b0000, 1, 3); cmt(7, 0); wbk(7); chk(0, 4'b1000, 1, 0, 0, "dup_stall"); tick();
    iss(7, 4'b0000, 1, 3); chk(1, 4'b0000, 0, 0, 0, "dup_ready"); tick();
    iss(8, 4'b0000, 1, 0); cmt(7, 0); wbk(7); chk(1, 4'b1000, 1, 0, 0, "swap"); tick();
    cmt(8, 1); wbk(8); chk(1, 4'b0001, 1, 0, 0, "killwb"); tick();
    chk(1, 4'b0000, 0, 0, 1, "killwb_pulse"); tick();

    // Reset mid-operation drops entries without a kill pulse
    iss(1, 4'b0000, 1, 1); tick();
    rst = 1'b1; cmt(1, 1); tick();
    rst = 1'b0;
    chk(1, 4'b0000, 0, 0, 0, "mid_reset"); tick();

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations never compared, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
